id_scoreboard_ctrl: RTL and testbench
=====================================

Name: id_scoreboard_ctrl

Overview:
- Issue controller for the decode stage; it sequences the IF/ID → ID/EX transfer.
- Keeps a per-register busy scoreboard of in-flight destination writes. It stalls decode on RAW/WAW hazards against the register file and clears entries on write-back.
- Handles flush (branch redirect) and backpressure from execute.
- Sits beside inst_dec. It drives the IF/ID and PC write enables and the ID/EX valid.

Parameters:
- WORD_SIZE, 32, instruction width.
- REG_ADDR_SIZE, 5, register index width.
- NUM_REGS, 32, architectural registers (2**REG_ADDR_SIZE).
- STALL_CNT_SIZE, 16, width of the saturating stall-cycle counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_if_id_valid  in  1  IF/ID register holds a live instruction.
- i_inst  in  WORD_SIZE  instruction from IF/ID (rd [11:7], rs1 [19:15], rs2 [24:20], opcode [6:0]).
- i_ex_ready  in  1  execute stage can accept an instruction.
- i_flush  in  1  redirect; kill the instruction in IF/ID.
- i_wb_valid  in  1  write-back this cycle.
- i_wb_reg  in  REG_ADDR_SIZE  write-back destination.
- o_id_ex_valid  out  1  instruction issues to ID/EX this cycle (combinational).
- o_if_id_wr_en  out  1  IF/ID may load next instruction (combinational).
- o_pc_wr_en  out  1  PC may advance; equals o_if_id_wr_en.
- o_busy_vec  out  NUM_REGS  registered scoreboard.
- o_state  out  2  RUN=0, STALL=1, FLUSH=2.
- o_stall_cnt  out  STALL_CNT_SIZE  hazard stall cycles, saturating.
- o_sb_err  out  1  sticky; write-back to a non-busy register.

Behaviour:
- Reset (i_rst=1 at an edge): busy_vec=0, state=RUN, stall_cnt=0, sb_err=0. During reset, o_id_ex_valid=0 and o_if_id_wr_en=1.
- Register usage from opcode:
  - uses_rs1: all except LUI, AUIPC, JAL.
  - uses_rs2: R (0110011), S (0100011), B (1100011).
  - writes_rd: R, I-ALU, load, JAL, JALR, LUI, AUIPC.
  - Unknown opcodes use and write nothing.
- Effective busy:
  - eff_busy = busy_vec & ~(i_wb_valid ? onehot(i_wb_reg) : 0).
  - Write-back clears before the check (same-cycle bypass).
  - Bit 0 is always 0.
- Hazard: (uses_rs1 & eff_busy[rs1]) | (uses_rs2 & eff_busy[rs2]) | (writes_rd & eff_busy[rd]). The rd term is the WAW check.
- issue = i_if_id_valid & i_ex_ready & ~hazard & ~i_flush & state!=FLUSH.
- o_id_ex_valid = issue.
- o_if_id_wr_en = issue | ~i_if_id_valid | state==FLUSH | i_flush.
- Scoreboard update at the edge:
  - Clear the write-back bit.
  - Then set bit rd if issue & writes_rd & rd!=0.
  - Set wins over clear on the same index.
- Write-back to a register whose busy_vec bit is 0 (including x0): sets sb_err, busy unchanged.
- FSM (i_flush has priority in all states):
  - RUN: i_flush → FLUSH; valid & hazard → STALL; else RUN.
  - STALL: i_flush → FLUSH; ~hazard (with bypass) → RUN. The instruction issues in the same cycle hazard clears, if i_ex_ready.
  - FLUSH: one cycle; no issue, IF/ID reloads; → RUN.
- stall_cnt increments in every STALL cycle and in every RUN cycle that detects a hazard. It saturates at all-ones.
- Backpressure (i_ex_ready=0) without a hazard does not count and does not change state.
- Flush does not modify busy_vec; in-flight writers still write back.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants;
  - field positions (rd 7, rs1 15, rs2 20, width 5);
  - FSM state encoding.
- One combinational sub-module inst_reg_usage: i_inst → uses_rs1, uses_rs2, writes_rd, rs1, rs2, rd.
- The scoreboard and FSM live in the top.

Test Plan:
- Reset: hold i_rst 2 cycles → busy_vec=0, o_state=0, o_stall_cnt=0, o_sb_err=0, o_if_id_wr_en=1.
- RAW:
  - Issue add x5,x1,x2 (0x002082B3), ex_ready=1 → o_id_ex_valid=1; busy_vec=0x00000020 next cycle.
  - Then sub x6,x5,x3 (0x40328333) → o_id_ex_valid=0, o_state=1, stall_cnt counts 1, 2, 3.
  - Pulse i_wb_valid, i_wb_reg=5 → issue that cycle; next busy_vec=0x00000040, o_state=0.
- Set/clear collision:
  - busy[5]=1; present addi x5,x0,1 (0x00100293) with wb_reg=5 the same cycle → issues; busy[5] stays 1.
  - addi x0,x0,0 (0x00000013) → issues; busy unchanged.
- Flush in STALL: assert i_flush → next o_state=2, o_id_ex_valid=0, o_if_id_wr_en=1, then o_state=0; busy_vec unchanged.
- Error/backpressure:
  - WB to x7 while busy[7]=0 → o_sb_err=1, sticky until reset.
  - i_ex_ready=0 with no hazard → no issue, o_if_id_wr_en=0, stall_cnt unchanged.
- Reset mid-STALL with busy_vec=0x000000E0 → next edge busy_vec=0, o_state=0, stall_cnt=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, instruction field positions and issue FSM encoding
package riscv_pkg;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int RD_POS  = 7;
    localparam int RS1_POS = 15;
    localparam int RS2_POS = 20;
    localparam int REG_W   = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/inst_reg_usage.sv
// inst_reg_usage: which register fields an instruction reads and writes
module inst_reg_usage
    import riscv_pkg::*;
#(
    parameter int WORD_SIZE     = 32,
    parameter int REG_ADDR_SIZE = 5
) (
    input  logic [WORD_SIZE-1:0]     i_inst,
    output logic                     o_uses_rs1,
    output logic                     o_uses_rs2,
    output logic                     o_writes_rd,
    output logic [REG_ADDR_SIZE-1:0] o_rs1,
    output logic [REG_ADDR_SIZE-1:0] o_rs2,
    output logic [REG_ADDR_SIZE-1:0] o_rd
);

    logic [6:0] op;
    logic       unused_bits;

    assign op          = i_inst[6:0];
    assign o_rd        = i_inst[RD_POS +: REG_ADDR_SIZE];
    assign o_rs1       = i_inst[RS1_POS +: REG_ADDR_SIZE];
    assign o_rs2       = i_inst[RS2_POS +: REG_ADDR_SIZE];
    assign unused_bits = ^{i_inst[WORD_SIZE-1:RS2_POS+REG_ADDR_SIZE], i_inst[RS1_POS-1:RD_POS+REG_ADDR_SIZE]};

    // unknown opcodes fall through to "touches nothing" so they never stall
    always_comb begin
        {o_uses_rs1, o_uses_rs2, o_writes_rd} = 3'b000;
        case (op)
            OP_OP:                         {o_uses_rs1, o_uses_rs2, o_writes_rd} = 3'b111;
            OP_IMM, OP_LOAD, OP_JALR:      {o_uses_rs1, o_uses_rs2, o_writes_rd} = 3'b101;
            OP_STORE, OP_BRANCH:           {o_uses_rs1, o_uses_rs2, o_writes_rd} = 3'b110;
            OP_JAL, OP_LUI, OP_AUIPC:      {o_uses_rs1, o_uses_rs2, o_writes_rd} = 3'b001;
            default:                       {o_uses_rs1, o_uses_rs2, o_writes_rd} = 3'b000;
        endcase
    end

endmodule

// File: rtl/id_scoreboard_ctrl.sv
// id_scoreboard_ctrl: decode issue control with busy-register scoreboard and stall FSM
module id_scoreboard_ctrl
    import riscv_pkg::*;
#(
    parameter int WORD_SIZE      = 32,
    parameter int REG_ADDR_SIZE  = 5,
    parameter int NUM_REGS       = 32,
    parameter int STALL_CNT_SIZE = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_if_id_valid,
    input  logic [WORD_SIZE-1:0]      i_inst,
    input  logic                      i_ex_ready,
    input  logic                      i_flush,
    input  logic                      i_wb_valid,
    input  logic [REG_ADDR_SIZE-1:0]  i_wb_reg,
    output logic                      o_id_ex_valid,
    output logic                      o_if_id_wr_en,
    output logic                      o_pc_wr_en,
    output logic [NUM_REGS-1:0]       o_busy_vec,
    output logic [1:0]                o_state,
    output logic [STALL_CNT_SIZE-1:0] o_stall_cnt,
    output logic                      o_sb_err
);

    logic                      uses_rs1, uses_rs2, writes_rd;
    logic [REG_ADDR_SIZE-1:0]  rs1, rs2, rd;
    logic [NUM_REGS-1:0]       busy_q, busy_d, wb_mask, set_mask, eff_busy;
    state_t                    state_q, state_d;
    logic [STALL_CNT_SIZE-1:0] cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic                      hazard, stall_hit, issue;

    inst_reg_usage #(
        .WORD_SIZE    (WORD_SIZE),
        .REG_ADDR_SIZE(REG_ADDR_SIZE)
    ) u_usage (
        .i_inst     (i_inst),
        .o_uses_rs1 (uses_rs1),
        .o_uses_rs2 (uses_rs2),
        .o_writes_rd(writes_rd),
        .o_rs1      (rs1),
        .o_rs2      (rs2),
        .o_rd       (rd)
    );

    // hazard check sees the scoreboard with this cycle's write-back already retired
    always_comb begin
        wb_mask   = i_wb_valid ? NUM_REGS'(1) << i_wb_reg : '0;
        eff_busy  = busy_q & ~wb_mask & ~NUM_REGS'(1);
        hazard    = (uses_rs1 & eff_busy[rs1]) | (uses_rs2 & eff_busy[rs2]) | (writes_rd & eff_busy[rd]);
        stall_hit = i_if_id_valid & hazard;
        issue     = ~i_rst & i_if_id_valid & i_ex_ready & ~hazard & ~i_flush & (state_q != ST_FLUSH);
        set_mask  = (issue & writes_rd & (rd != '0)) ? NUM_REGS'(1) << rd : '0;
    end

    assign o_id_ex_valid = issue;
    assign o_if_id_wr_en = i_rst | issue | ~i_if_id_valid | (state_q == ST_FLUSH) | i_flush;
    assign o_pc_wr_en    = o_if_id_wr_en;
    assign o_busy_vec    = busy_q;
    assign o_state       = state_q;
    assign o_stall_cnt   = cnt_q;
    assign o_sb_err      = err_q;

    // next state: flush dominates, a live hazard holds/enters STALL, FLUSH lasts one cycle
    always_comb begin
        state_d = i_flush ? ST_FLUSH : (state_q != ST_FLUSH && stall_hit) ? ST_STALL : ST_RUN;
        busy_d  = (busy_q & ~wb_mask) | set_mask;
        cnt_d   = ((state_q == ST_STALL || (state_q == ST_RUN && stall_hit)) && cnt_q != '1)
                  ? cnt_q + STALL_CNT_SIZE'(1) : cnt_q;
        err_d   = err_q | (i_wb_valid & ~busy_q[i_wb_reg]);
    end

    // state, scoreboard, stall counter and sticky error registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            busy_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_id_scoreboard_ctrl.sv
// tb_id_scoreboard_ctrl: directed + random stimulus, reference model feeds a queue checked by a monitor
module tb_id_scoreboard_ctrl;

    logic        i_clk, i_rst, i_if_id_valid, i_ex_ready, i_flush, i_wb_valid;
    logic [31:0] i_inst;
    logic [4:0]  i_wb_reg;
    logic        o_id_ex_valid, o_if_id_wr_en, o_pc_wr_en, o_sb_err;
    logic [31:0] o_busy_vec;
    logic [1:0]  o_state;
    logic [15:0] o_stall_cnt;

    id_scoreboard_ctrl dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_if_id_valid(i_if_id_valid), .i_inst(i_inst),
        .i_ex_ready(i_ex_ready), .i_flush(i_flush), .i_wb_valid(i_wb_valid), .i_wb_reg(i_wb_reg),
        .o_id_ex_valid(o_id_ex_valid), .o_if_id_wr_en(o_if_id_wr_en), .o_pc_wr_en(o_pc_wr_en),
        .o_busy_vec(o_busy_vec), .o_state(o_state), .o_stall_cnt(o_stall_cnt), .o_sb_err(o_sb_err)
    );

    typedef struct {
        logic        v;
        logic        wr;
        logic [31:0] busy;
        logic [1:0]  st;
        logic [15:0] cnt;
        logic        err;
        int          id;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          n_items = 0;
    logic [31:0] m_busy = '0;
    int          m_state = 0;
    int          m_cnt = 0;
    bit          m_err = 0;

    initial i_clk = 0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s item=%0d got=%h expected=%h", name, id, act, exp);
        end
    endtask

    // monitor: every cycle the DUT presents outputs, compare against the oldest expectation
    always @(negedge i_clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("id_ex_valid", e.id, 32'(o_id_ex_valid), 32'(e.v));
            chk("if_id_wr_en", e.id, 32'(o_if_id_wr_en), 32'(e.wr));
            chk("pc_wr_en", e.id, 32'(o_pc_wr_en), 32'(e.wr));
            chk("busy_vec", e.id, o_busy_vec, e.busy);
            chk("state", e.id, 32'(o_state), 32'(e.st));
            chk("stall_cnt", e.id, 32'(o_stall_cnt), 32'(e.cnt));
            chk("sb_err", e.id, 32'(o_sb_err), 32'(e.err));
        end
    end

    function automatic void usage(input logic [31:0] inst, output bit u1, output bit u2, output bit w);
        case (inst[6:0])
            7'b0110011:                         {u1, u2, w} = 3'b111;
            7'b0010011, 7'b0000011, 7'b1100111: {u1, u2, w} = 3'b101;
            7'b0100011, 7'b1100011:             {u1, u2, w} = 3'b110;
            7'b1101111, 7'b0110111, 7'b0010111: {u1, u2, w} = 3'b001;
            default:                            {u1, u2, w} = 3'b000;
        endcase
    endfunction

    // one cycle: drive inputs, predict this cycle's outputs, advance the model across the edge
    task automatic step(input bit rst, input bit v, input logic [31:0] inst, input bit rdy,
                        input bit fl, input bit wbv, input logic [4:0] wbr);
        exp_t        e;
        bit          u1, u2, w, haz, iss;
        logic [31:0] avail;
        int          rd, rs1, rs2;
        i_rst = rst; i_if_id_valid = v; i_inst = inst; i_ex_ready = rdy;
        i_flush = fl; i_wb_valid = wbv; i_wb_reg = wbr;
        usage(inst, u1, u2, w);
        rd = int'(inst[11:7]); rs1 = int'(inst[19:15]); rs2 = int'(inst[24:20]);
        avail = m_busy;
        if (wbv) avail[wbr] = 1'b0;
        avail[0] = 1'b0;
        haz = (u1 && avail[rs1]) || (u2 && avail[rs2]) || (w && avail[rd]);
        iss = !rst && v && rdy && !haz && !fl && m_state != 2;
        e.v = iss;
        e.wr = rst || iss || !v || m_state == 2 || fl;
        e.busy = m_busy; e.st = 2'(m_state); e.cnt = 16'(m_cnt); e.err = m_err;
        e.id = n_items++;
        q.push_back(e);
        if (rst) begin
            m_busy = '0; m_state = 0; m_cnt = 0; m_err = 0;
        end else begin
            if (m_state == 1 || (m_state == 0 && v && haz)) m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
            if (wbv && !m_busy[wbr]) m_err = 1;
            if (wbv) m_busy[wbr] = 1'b0;
            if (iss && w && rd != 0) m_busy[rd] = 1'b1;
            if (fl) m_state = 2;
            else if (m_state != 2 && v && haz) m_state = 1;
            else m_state = 0;
        end
        @(posedge i_clk);
        #1;
    endtask

    logic [6:0] ops[10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};

    initial begin
        i_rst = 1; i_if_id_valid = 0; i_inst = '0; i_ex_ready = 0;
        i_flush = 0; i_wb_valid = 0; i_wb_reg = '0;
        @(posedge i_clk);
        #1;
        step(1, 0, 32'h0, 0, 0, 0, 5'd0);
        step(1, 1, 32'h002082B3, 1, 0, 0, 5'd0);
        step(0, 1, 32'h002082B3, 1, 0, 0, 5'd0);
        step(0, 1, 32'h40328333, 1, 0, 0, 5'd0);
        step(0, 1, 32'h40328333, 1, 0, 0, 5'd0);
        step(0, 1, 32'h40328333, 1, 0, 0, 5'd0);
        step(0, 1, 32'h40328333, 1, 0, 1, 5'd5);
        step(0, 1, 32'h00100293, 1, 0, 0, 5'd0);
        step(0, 1, 32'h00100293, 1, 0, 1, 5'd5);
        step(0, 1, 32'h00000013, 1, 0, 0, 5'd0);
        step(0, 1, 32'h40328333, 1, 0, 0, 5'd0);
        step(0, 1, 32'h40328333, 1, 0, 0, 5'd0);
        step(0, 1, 32'h40328333, 1, 1, 0, 5'd0);
        step(0, 1, 32'h40328333, 1, 0, 0, 5'd0);
        step(0, 0, 32'h0, 1, 0, 1, 5'd7);
        step(0, 1, 32'h000004B3, 0, 0, 0, 5'd0);
        step(0, 1, 32'h000004B3, 0, 0, 0, 5'd0);
        step(0, 1, 32'h00100393, 1, 0, 0, 5'd0);
        step(0, 1, 32'h40328333, 1, 0, 0, 5'd0);
        step(0, 1, 32'h40328333, 1, 0, 0, 5'd0);
        step(1, 1, 32'h40328333, 1, 0, 0, 5'd0);
        step(0, 0, 32'h0, 1, 0, 0, 5'd0);
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] inst;
            logic [4:0]  r;
            bit          wbv;
            inst = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
                    5'($urandom_range(0, 7)), ops[$urandom_range(0, 9)]};
            r = 5'($urandom_range(0, 7));
            wbv = m_busy[r] ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 30) == 0);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 85, inst,
                 $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 5, wbv, r);
        end
        for (int t = 0; t < 10 && q.size() != 0; t++) @(posedge i_clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
